cmd_assembler: RTL and testbench

Sits between the KnightsTour UART receiver/transmitter and cmd_proc. It assembles two consecutive received bytes (high byte first) into one 16-bit command, e.g. 0x43F1, and presents it with a held cmd_rdy flag. It also drives the UART transmitter with response bytes such as 0xA5, using a one-deep pending buffer. An inter-byte timeout discards half-received frames so the link resynchronises after a dropped byte.

---
 rtl/cmd_assembler_if.sv | 27 ++
 rtl/cmd_assembler.sv | 150 +++++++++++++++
 tb/tb_cmd_assembler.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/cmd_assembler_if.sv
// Byte-side (UART RX/TX) and command-side (cmd_proc) signals of cmd_assembler.
// The master drives the UART/cmd_proc inputs. The slave is the assembler itself.
interface cmd_assembler_if;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        clr_rx_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        send_resp;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        resp_sent;
  logic        frame_err;

  modport master (
    output rx_rdy, rx_data, clr_cmd_rdy, resp, send_resp, tx_done,
    input  clr_rx_rdy, cmd, cmd_rdy, trmt, tx_data, resp_sent, frame_err
  );

  modport slave (
    input  rx_rdy, rx_data, clr_cmd_rdy, resp, send_resp, tx_done,
    output clr_rx_rdy, cmd, cmd_rdy, trmt, tx_data, resp_sent, frame_err
  );
endinterface

// File: rtl/cmd_assembler.sv
// Assembles two UART bytes (high first) into a 16-bit command with an inter-byte timeout.
// Also sequences response bytes to the UART transmitter through a one-deep pending buffer.
//   state      | meaning
//   RX_IDLE    | waiting for the high byte
//   RX_WAIT_LO | high byte held, timing the gap to the low byte
//   TX_IDLE    | transmitter free
//   TX_BUSY    | byte in flight, may hold one pending response
module cmd_assembler #(
  parameter int TIMEOUT_CYC = 500000,
  parameter int CNT_W       = 20
) (
  input logic            clk,
  input logic            rst,
  cmd_assembler_if.slave bus
);

  typedef enum logic {RX_IDLE, RX_WAIT_LO} rx_state_e;
  typedef enum logic {TX_IDLE, TX_BUSY}    tx_state_e;

  localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(TIMEOUT_CYC - 1);

  rx_state_e        rx_state_q, rx_state_d;
  tx_state_e        tx_state_q, tx_state_d;
  logic [7:0]       hi_q, hi_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [15:0]      cmd_q, cmd_d;
  logic             cmd_rdy_q, cmd_rdy_d;
  logic             clr_rx_rdy_q, clr_rx_rdy_d;
  logic             frame_err_q, frame_err_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             trmt_q, trmt_d;
  logic             resp_sent_q, resp_sent_d;
  logic [7:0]       pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q   <= RX_IDLE;
      tx_state_q   <= TX_IDLE;
      hi_q         <= '0;
      timer_q      <= '0;
      cmd_q        <= '0;
      cmd_rdy_q    <= 1'b0;
      clr_rx_rdy_q <= 1'b0;
      frame_err_q  <= 1'b0;
      tx_data_q    <= '0;
      trmt_q       <= 1'b0;
      resp_sent_q  <= 1'b0;
      pend_q       <= '0;
      pend_vld_q   <= 1'b0;
    end else begin
      rx_state_q   <= rx_state_d;
      tx_state_q   <= tx_state_d;
      hi_q         <= hi_d;
      timer_q      <= timer_d;
      cmd_q        <= cmd_d;
      cmd_rdy_q    <= cmd_rdy_d;
      clr_rx_rdy_q <= clr_rx_rdy_d;
      frame_err_q  <= frame_err_d;
      tx_data_q    <= tx_data_d;
      trmt_q       <= trmt_d;
      resp_sent_q  <= resp_sent_d;
      pend_q       <= pend_d;
      pend_vld_q   <= pend_vld_d;
    end
  end

  // The ack flop masks rx_rdy for one cycle so a held byte is taken only once.
  always_comb begin
    accept       = bus.rx_rdy && !clr_rx_rdy_q;
    rx_state_d   = rx_state_q;
    hi_d         = hi_q;
    timer_d      = timer_q;
    cmd_d        = cmd_q;
    cmd_rdy_d    = cmd_rdy_q && !bus.clr_cmd_rdy;
    clr_rx_rdy_d = accept;
    frame_err_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (accept) begin
          hi_d       = bus.rx_data;
          timer_d    = '0;
          cmd_rdy_d  = 1'b0;
          rx_state_d = RX_WAIT_LO;
        end
      end
      RX_WAIT_LO: begin
        if (accept) begin
          cmd_d      = {hi_q, bus.rx_data};
          cmd_rdy_d  = 1'b1;
          rx_state_d = RX_IDLE;
        end else if (timer_q == TIMER_LAST) begin
          hi_d        = '0;
          frame_err_d = 1'b1;
          rx_state_d  = RX_IDLE;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    tx_state_d  = tx_state_q;
    tx_data_d   = tx_data_q;
    trmt_d      = 1'b0;
    resp_sent_d = 1'b0;
    pend_d      = pend_q;
    pend_vld_d  = pend_vld_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (bus.send_resp) begin
          tx_data_d  = bus.resp;
          trmt_d     = 1'b1;
          tx_state_d = TX_BUSY;
        end
      end
      TX_BUSY: begin
        if (bus.tx_done) begin
          resp_sent_d = 1'b1;
          if (pend_vld_q) begin
            tx_data_d  = pend_q;
            trmt_d     = 1'b1;
            pend_vld_d = 1'b0;
          end else if (bus.send_resp) begin
            tx_data_d = bus.resp;
            trmt_d    = 1'b1;
          end else begin
            tx_state_d = TX_IDLE;
          end
        end else if (bus.send_resp && !pend_vld_q) begin
          pend_d     = bus.resp;
          pend_vld_d = 1'b1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  assign bus.clr_rx_rdy = clr_rx_rdy_q;
  assign bus.cmd        = cmd_q;
  assign bus.cmd_rdy    = cmd_rdy_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.tx_data    = tx_data_q;
  assign bus.trmt       = trmt_q;
  assign bus.resp_sent  = resp_sent_q;

endmodule

// File: tb/tb_cmd_assembler.sv
// Directed and randomized bench for cmd_assembler.
// A transaction-level model predicts every output on every cycle.
module tb_cmd_assembler;
  localparam bit FAST_SIM    = 1'b1;
  localparam int TIMEOUT_CYC = FAST_SIM ? 2000 : 500000;
  localparam int CNT_W       = 20;

  logic clk = 1'b0;
  logic rst;
  cmd_assembler_if bus();

  cmd_assembler #(.TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int n_clr, n_trmt, n_sent, n_ferr;

  // expected outputs after the next edge
  logic [15:0] e_cmd;
  logic        e_cmd_rdy, e_clr, e_trmt, e_sent, e_ferr;
  logic [7:0]  e_tx;
  // frame and response bookkeeping
  bit          m_have_hi;
  logic [7:0]  m_hi;
  int          m_waited;
  bit          m_busy;
  logic [7:0]  m_pend[$];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_step();
    logic acc;
    if (rst) begin
      e_cmd = '0; e_cmd_rdy = 1'b0; e_clr = 1'b0; e_trmt = 1'b0;
      e_tx = '0; e_sent = 1'b0; e_ferr = 1'b0;
      m_have_hi = 1'b0; m_waited = 0; m_busy = 1'b0; m_pend.delete();
      return;
    end
    acc    = bus.rx_rdy && !e_clr;
    e_clr  = acc;
    e_ferr = 1'b0;
    if (bus.clr_cmd_rdy) e_cmd_rdy = 1'b0;
    if (!m_have_hi) begin
      if (acc) begin
        m_hi = bus.rx_data; m_have_hi = 1'b1; m_waited = 0; e_cmd_rdy = 1'b0;
      end
    end else if (acc) begin
      e_cmd = {m_hi, bus.rx_data}; e_cmd_rdy = 1'b1; m_have_hi = 1'b0;
    end else if (m_waited == TIMEOUT_CYC - 1) begin
      m_have_hi = 1'b0; e_ferr = 1'b1;
    end else begin
      m_waited++;
    end

    e_trmt = 1'b0;
    e_sent = 1'b0;
    if (!m_busy) begin
      if (bus.send_resp) begin e_tx = bus.resp; e_trmt = 1'b1; m_busy = 1'b1; end
    end else if (bus.tx_done) begin
      e_sent = 1'b1;
      if (m_pend.size() > 0) begin e_tx = m_pend.pop_front(); e_trmt = 1'b1; end
      else if (bus.send_resp) begin e_tx = bus.resp; e_trmt = 1'b1; end
      else m_busy = 1'b0;
    end else if (bus.send_resp && m_pend.size() == 0) begin
      m_pend.push_back(bus.resp);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("cmd",        bus.cmd,                e_cmd);
    chk("cmd_rdy",    16'(bus.cmd_rdy),    16'(e_cmd_rdy));
    chk("clr_rx_rdy", 16'(bus.clr_rx_rdy), 16'(e_clr));
    chk("trmt",       16'(bus.trmt),       16'(e_trmt));
    chk("tx_data",    16'(bus.tx_data),    16'(e_tx));
    chk("resp_sent",  16'(bus.resp_sent),  16'(e_sent));
    chk("frame_err",  16'(bus.frame_err),  16'(e_ferr));
    n_clr  += int'(bus.clr_rx_rdy);
    n_trmt += int'(bus.trmt);
    n_sent += int'(bus.resp_sent);
    n_ferr += int'(bus.frame_err);
  endtask

  // UART RX: raise rx_rdy, drop it on the edge after the ack is seen
  task automatic send_byte(input logic [7:0] b, input bit with_clr);
    int k;
    bus.rx_rdy = 1'b1; bus.rx_data = b; bus.clr_cmd_rdy = with_clr;
    tick();
    bus.clr_cmd_rdy = 1'b0;
    k = 0;
    while (!bus.clr_rx_rdy && k < 4) begin tick(); k++; end
    chk("rx_ack_seen", 16'(bus.clr_rx_rdy), 16'h1);
    tick();
    bus.rx_rdy = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.rx_rdy = 1'b0; bus.rx_data = '0; bus.clr_cmd_rdy = 1'b0;
    bus.resp = '0; bus.send_resp = 1'b0; bus.tx_done = 1'b0;
    n_clr = 0; n_trmt = 0; n_sent = 0; n_ferr = 0;
    tick(); tick();
    chk("rst_cmd",     bus.cmd,              16'h0000);
    chk("rst_cmd_rdy", 16'(bus.cmd_rdy), 16'h0);
    chk("rst_trmt",    16'(bus.trmt),    16'h0);
    rst = 1'b0;

    // two bytes into one command, ack once per byte
    n_clr = 0;
    send_byte(8'h43, 1'b0);
    send_byte(8'hF1, 1'b0);
    chk("t1_ack_count", 16'(n_clr), 16'd2);
    chk("t1_cmd",       bus.cmd,          16'h43F1);
    repeat (5) tick();
    chk("t1_cmd_rdy_held", 16'(bus.cmd_rdy), 16'h1);
    bus.clr_cmd_rdy = 1'b1; tick(); bus.clr_cmd_rdy = 1'b0;
    chk("t1_cmd_rdy_clr", 16'(bus.cmd_rdy), 16'h0);

    // timeout discards the half frame
    n_ferr = 0;
    send_byte(8'h47, 1'b0);
    repeat (TIMEOUT_CYC + 5) tick();
    chk("t2_ferr_count", 16'(n_ferr), 16'd1);
    chk("t2_cmd_kept",   bus.cmd,          16'h43F1);
    send_byte(8'h4B, 1'b0);
    send_byte(8'hF1, 1'b0);
    repeat (10) tick();
    chk("t2_cmd", bus.cmd, 16'h4BF1);

    // low byte accepted exactly on the last timer cycle
    bus.rx_rdy = 1'b1; bus.rx_data = 8'h12;
    tick(); tick();
    bus.rx_rdy = 1'b0;
    repeat (TIMEOUT_CYC - 2) tick();
    bus.rx_rdy = 1'b1; bus.rx_data = 8'h34;
    tick();
    chk("t2b_cmd",     bus.cmd,              16'h1234);
    chk("t2b_cmd_rdy", 16'(bus.cmd_rdy), 16'h1);
    tick();
    bus.rx_rdy = 1'b0;
    repeat (10) tick();
    chk("t2b_ferr_count", 16'(n_ferr), 16'd1);

    // completion beats a simultaneous clear
    send_byte(8'h20, 1'b0);
    send_byte(8'h00, 1'b1);
    chk("t3_cmd",     bus.cmd,              16'h2000);
    chk("t3_cmd_rdy", 16'(bus.cmd_rdy), 16'h1);

    // single response
    n_trmt = 0; n_sent = 0;
    bus.send_resp = 1'b1; bus.resp = 8'hA5; tick(); bus.send_resp = 1'b0;
    chk("t4_trmt", 16'(bus.trmt),    16'h1);
    chk("t4_tx",   16'(bus.tx_data), 16'h00A5);
    repeat (100) tick();
    bus.tx_done = 1'b1; tick(); bus.tx_done = 1'b0;
    chk("t4_sent", 16'(bus.resp_sent), 16'h1);
    repeat (3) tick();
    chk("t4_sent_count", 16'(n_sent), 16'd1);

    // pending buffer: second kept, third dropped
    n_trmt = 0; n_sent = 0;
    bus.send_resp = 1'b1; bus.resp = 8'hA5; tick();
    bus.resp = 8'h5A; tick();
    bus.resp = 8'h33; tick();
    bus.send_resp = 1'b0;
    repeat (20) tick();
    bus.tx_done = 1'b1; tick(); bus.tx_done = 1'b0;
    chk("t5_b2b_trmt", 16'(bus.trmt),    16'h1);
    chk("t5_b2b_tx",   16'(bus.tx_data), 16'h005A);
    repeat (20) tick();
    bus.tx_done = 1'b1; tick(); bus.tx_done = 1'b0;
    repeat (5) tick();
    bus.tx_done = 1'b1; tick(); bus.tx_done = 1'b0;
    repeat (5) tick();
    chk("t5_trmt_count", 16'(n_trmt), 16'd2);
    chk("t5_sent_count", 16'(n_sent), 16'd2);

    // reset in the middle of a frame and a pending transmit
    bus.send_resp = 1'b1; bus.resp = 8'h77; tick();
    bus.resp = 8'h88; tick();
    bus.send_resp = 1'b0;
    send_byte(8'h60, 1'b0);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t6_cmd",  bus.cmd,              16'h0000);
    chk("t6_tx",   16'(bus.tx_data), 16'h0000);
    n_trmt = 0; n_sent = 0;
    tick();
    bus.tx_done = 1'b1; tick(); bus.tx_done = 1'b0;
    send_byte(8'h40, 1'b0);
    send_byte(8'h01, 1'b0);
    chk("t6_cmd_new",    bus.cmd,          16'h4001);
    chk("t6_no_trmt",    16'(n_trmt), 16'd0);
    chk("t6_no_sent",    16'(n_sent), 16'd0);

    // random traffic on both paths against the model
    for (int i = 0; i < 4000; i++) begin
      rst             = ($urandom_range(0, 399) == 0);
      bus.rx_rdy      = ($urandom_range(0, 2) == 0);
      bus.rx_data     = 8'($urandom);
      bus.clr_cmd_rdy = ($urandom_range(0, 5) == 0);
      bus.send_resp   = ($urandom_range(0, 3) == 0);
      bus.resp        = 8'($urandom);
      bus.tx_done     = ($urandom_range(0, 7) == 0);
      tick();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
